// File: rtl/rc4_crack_scheduler.sv
// rc4_crack_scheduler
//   Splits a 24-bit RC4 key space into fixed-size chunks and hands them out
//   round-robin to NUM_CORES cracker cores. The search stops when the space
//   is exhausted and every core has reported back, or when any core reports
//   a hit. After a hit, the remaining cores are aborted.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-low reset
//   start        one-cycle request to begin a search (honoured only in IDLE)
//   busy         high while a search is in progress
//   done         one-cycle pulse when the search ends
//   found        search result, held until the next accepted start
//   found_key    winning key, valid while found=1
//   core_start   one-hot chunk-issue pulse
//   core_base    first key of the issued chunk (0 when no issue)
//   core_last    last key of the issued chunk (0 when no issue)
//   core_abort   per-core level asking the core to stop its chunk
//   core_ready   core idle and able to accept a chunk
//   core_done    per-core pulse, chunk finished
//   core_hit     qualified by core_done, key found in chunk
//   core_key     core i key at bits [24*i+23:24*i]
module rc4_crack_scheduler #(
  parameter int          NUM_CORES = 4,
  parameter logic [23:0] CHUNK     = 24'h010000,
  parameter logic [23:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [23:0]             found_key,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [23:0]             core_base,
  output logic [23:0]             core_last,
  output logic [NUM_CORES-1:0]    core_abort,
  input  logic [NUM_CORES-1:0]    core_ready,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES-1:0]    core_hit,
  input  logic [NUM_CORES*24-1:0] core_key
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, ABORT, FINISH} state_t;

  state_t                 state_reg, state_next;
  logic [24:0]            next_base_reg, next_base_next;
  logic [NUM_CORES-1:0]   assigned_reg, assigned_next;
  logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic                   found_reg, found_next;
  logic [23:0]            found_key_reg, found_key_next;
  logic [NUM_CORES-1:0]   core_start_reg, core_start_next;
  logic [23:0]            core_base_reg, core_base_next;
  logic [23:0]            core_last_reg, core_last_next;

  // Hit handling: isolate the lowest-index hit and mux its key out.
  logic [NUM_CORES-1:0]   hit_vec, hit_onehot;
  logic [23:0]            key_or [NUM_CORES+1];
  logic [23:0]            hit_key;

  assign hit_vec    = core_done & core_hit;
  assign hit_onehot = hit_vec & (~hit_vec + 1'b1);
  assign key_or[0]  = '0;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_key_mux
      assign key_or[gi+1] = key_or[gi] | ({24{hit_onehot[gi]}} & core_key[24*gi +: 24]);
    end
  endgenerate

  assign hit_key = key_or[NUM_CORES];

  // A core finishing this cycle is not eligible until the next cycle.
  logic [NUM_CORES-1:0]   eligible;
  logic                   grant_valid;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       cand_idx;
  int                     cand;

  assign eligible = core_ready & ~assigned_reg & ~core_done;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      cand_idx = PTR_W'(cand);
      if (!grant_valid && eligible[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // 25-bit arithmetic so chunk bounds near the top of the space never wrap.
  logic [24:0] chunk_end, base_after;
  assign chunk_end  = next_base_reg + {1'b0, CHUNK} - 25'd1;
  assign base_after = next_base_reg + {1'b0, CHUNK};

  always_comb begin
    state_next      = state_reg;
    next_base_next  = next_base_reg;
    assigned_next   = assigned_reg & ~core_done;
    rr_ptr_next     = rr_ptr_reg;
    found_next      = found_reg;
    found_key_next  = found_key_reg;
    core_start_next = '0;
    core_base_next  = '0;
    core_last_next  = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          next_base_next = '0;
          assigned_next  = '0;
          found_next     = 1'b0;
          found_key_next = '0;
          state_next     = DISPATCH;
        end
      end
      DISPATCH: begin
        if (|hit_vec) begin
          found_next     = 1'b1;
          found_key_next = hit_key;
          state_next     = ABORT;
        end else if (next_base_reg > {1'b0, KEY_MAX}) begin
          state_next = DRAIN;
        end else if (grant_valid) begin
          core_start_next[grant_idx] = 1'b1;
          core_base_next             = next_base_reg[23:0];
          core_last_next             = (chunk_end > {1'b0, KEY_MAX}) ? KEY_MAX : chunk_end[23:0];
          assigned_next[grant_idx]   = 1'b1;
          next_base_next             = base_after;
          rr_ptr_next = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
          if (base_after > {1'b0, KEY_MAX}) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (|hit_vec) begin
          found_next     = 1'b1;
          found_key_next = hit_key;
          state_next     = ABORT;
        end else if (assigned_reg == '0) begin
          state_next = FINISH;
        end
      end
      ABORT: begin
        // A core is considered stopped once it reports ready or done; hits
        // arriving now are ignored.
        assigned_next = assigned_reg & ~(core_ready | core_done);
        if (assigned_reg == '0) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      next_base_reg  <= '0;
      assigned_reg   <= '0;
      rr_ptr_reg     <= '0;
      found_reg      <= 1'b0;
      found_key_reg  <= '0;
      core_start_reg <= '0;
      core_base_reg  <= '0;
      core_last_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      next_base_reg  <= next_base_next;
      assigned_reg   <= assigned_next;
      rr_ptr_reg     <= rr_ptr_next;
      found_reg      <= found_next;
      found_key_reg  <= found_key_next;
      core_start_reg <= core_start_next;
      core_base_reg  <= core_base_next;
      core_last_reg  <= core_last_next;
    end
  end

  assign busy       = (state_reg == DISPATCH) || (state_reg == DRAIN) || (state_reg == ABORT);
  assign done       = (state_reg == FINISH);
  assign found      = found_reg;
  assign found_key  = found_key_reg;
  assign core_start = core_start_reg;
  assign core_base  = core_base_reg;
  assign core_last  = core_last_reg;
  assign core_abort = (state_reg == ABORT) ? assigned_reg : '0;

endmodule

// File: tb/tb_rc4_crack_scheduler.sv
// Directed testbench for rc4_crack_scheduler. Two instances share clock,
// reset and core inputs: dut_a (4 cores, CHUNK 4, KEY_MAX 15) and
// dut_b (same but KEY_MAX 13, exercising the clipped last chunk).
module tb_rc4_crack_scheduler;

  logic        clk;
  logic        reset;
  logic        start_a, start_b;
  logic [3:0]  core_ready, core_done, core_hit;
  logic [95:0] core_key;

  logic        busy_a, done_a, found_a;
  logic [23:0] found_key_a, core_base_a, core_last_a;
  logic [3:0]  core_start_a, core_abort_a;

  logic        busy_b, done_b, found_b;
  logic [23:0] found_key_b, core_base_b, core_last_b;
  logic [3:0]  core_start_b, core_abort_b;

  int checks = 0;
  int passed = 0;

  rc4_crack_scheduler #(.NUM_CORES(4), .CHUNK(24'd4), .KEY_MAX(24'd15)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .busy(busy_a), .done(done_a), .found(found_a), .found_key(found_key_a),
    .core_start(core_start_a), .core_base(core_base_a), .core_last(core_last_a),
    .core_abort(core_abort_a), .core_ready(core_ready), .core_done(core_done),
    .core_hit(core_hit), .core_key(core_key)
  );

  rc4_crack_scheduler #(.NUM_CORES(4), .CHUNK(24'd4), .KEY_MAX(24'd13)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(busy_b), .done(done_b), .found(found_b), .found_key(found_key_b),
    .core_start(core_start_b), .core_base(core_base_b), .core_last(core_last_b),
    .core_abort(core_abort_b), .core_ready(core_ready), .core_done(core_done),
    .core_hit(core_hit), .core_key(core_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the done pulse of one instance; callers compare afterwards.
  task automatic wait_done(input bit sel_b, input int limit);
    int n;
    n = 0;
    while (((sel_b ? done_b : done_a) !== 1'b1) && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    core_ready = 4'b1111; core_done = '0; core_hit = '0; core_key = '0;
    tick(); tick();
    $display("reset: applied for 2 cycles");
    checks++; if ({busy_a, done_a, found_a} !== 3'b000) $display("FAIL reset_flags_a: got %b want 000", {busy_a, done_a, found_a}); else passed++;
    checks++; if (found_key_a !== 24'd0) $display("FAIL reset_found_key_a: got %0h want 0", found_key_a); else passed++;
    checks++; if (core_start_a !== 4'b0000) $display("FAIL reset_core_start_a: got %b want 0000", core_start_a); else passed++;
    checks++; if ({core_base_a, core_last_a} !== 48'd0) $display("FAIL reset_base_last_a: got %0h/%0h want 0/0", core_base_a, core_last_a); else passed++;
    checks++; if (core_abort_a !== 4'b0000) $display("FAIL reset_abort_a: got %b want 0000", core_abort_a); else passed++;
    checks++; if ({busy_b, done_b, found_b, core_start_b, core_abort_b} !== 11'd0) $display("FAIL reset_b: got %b want 0", {busy_b, done_b, found_b, core_start_b, core_abort_b}); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    logic [3:0]  es;
    logic [23:0] eb, el;
    start_a = 1'b1; tick(); start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) $display("FAIL sweep_busy_after_start: got %b want 1", busy_a); else passed++;
    checks++; if (core_start_a !== 4'b0000) $display("FAIL sweep_no_issue_yet: got %b want 0000", core_start_a); else passed++;
    for (int g = 0; g < 4; g++) begin
      es = 4'b0001 << g;
      eb = 24'(4 * g);
      el = 24'(4 * g + 3);
      tick();
      $display("sweep grant %0d: core_start=%b base=%0d last=%0d", g, core_start_a, core_base_a, core_last_a);
      checks++; if ({core_start_a, core_base_a, core_last_a} !== {es, eb, el})
        $display("FAIL sweep_grant%0d: got %b/%0d/%0d want %b/%0d/%0d", g, core_start_a, core_base_a, core_last_a, es, eb, el); else passed++;
    end
    tick();
    checks++; if ({core_start_a, core_base_a, core_last_a} !== 52'd0) $display("FAIL sweep_idle_outputs_zero: got %b/%0d/%0d want 0/0/0", core_start_a, core_base_a, core_last_a); else passed++;
    for (int g = 0; g < 4; g++) begin
      core_done = 4'b0001 << g; tick();
    end
    core_done = '0;
    checks++; if ({busy_a, done_a} !== 2'b10) $display("FAIL sweep_still_busy: got %b want 10", {busy_a, done_a}); else passed++;
    wait_done(1'b0, 10);
    $display("sweep: done=%b found=%b busy=%b", done_a, found_a, busy_a);
    checks++; if ({done_a, found_a, busy_a} !== 3'b100) $display("FAIL sweep_done: got %b want 100", {done_a, found_a, busy_a}); else passed++;
    tick();
    checks++; if (done_a !== 1'b0) $display("FAIL sweep_done_pulse: got %b want 0", done_a); else passed++;
  endtask

  task automatic test_clip();
    logic [3:0]  es;
    logic [23:0] eb, el;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int g = 0; g < 4; g++) begin
      es = 4'b0001 << g;
      eb = 24'(4 * g);
      el = (g == 3) ? 24'd13 : 24'(4 * g + 3);
      tick();
      $display("clip grant %0d: core_start=%b base=%0d last=%0d", g, core_start_b, core_base_b, core_last_b);
      checks++; if ({core_start_b, core_base_b, core_last_b} !== {es, eb, el})
        $display("FAIL clip_grant%0d: got %b/%0d/%0d want %b/%0d/%0d", g, core_start_b, core_base_b, core_last_b, es, eb, el); else passed++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (core_start_b !== 4'b0000) $display("FAIL clip_no_fifth_issue: got %b want 0000", core_start_b); else passed++;
    end
    core_done = 4'b1111; tick(); core_done = '0;
    wait_done(1'b1, 10);
    $display("clip: done=%b found=%b", done_b, found_b);
    checks++; if ({done_b, found_b} !== 2'b10) $display("FAIL clip_done: got %b want 10", {done_b, found_b}); else passed++;
    tick();
  endtask

  task automatic test_hit();
    core_ready = 4'b1111;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (4) tick();
    checks++; if (core_start_a !== 4'b1000) $display("FAIL hit_last_grant: got %b want 1000", core_start_a); else passed++;
    core_ready = 4'b0000;
    core_done = 4'b0100; core_hit = 4'b0100; core_key[48 +: 24] = 24'h00000A;
    tick();
    core_done = '0; core_hit = '0;
    $display("hit: core 2 key=%0h abort=%b", found_key_a, core_abort_a);
    checks++; if (core_abort_a !== 4'b1011) $display("FAIL hit_abort: got %b want 1011", core_abort_a); else passed++;
    checks++; if ({found_a, found_key_a} !== {1'b1, 24'h00000A}) $display("FAIL hit_latch: got %b/%0h want 1/a", found_a, found_key_a); else passed++;
    checks++; if ({busy_a, done_a} !== 2'b10) $display("FAIL hit_busy: got %b want 10", {busy_a, done_a}); else passed++;
    tick(); tick();
    checks++; if (core_abort_a !== 4'b1011) $display("FAIL hit_abort_held: got %b want 1011", core_abort_a); else passed++;
    core_ready = 4'b1011;
    tick();
    checks++; if (core_abort_a !== 4'b0000) $display("FAIL hit_abort_release: got %b want 0000", core_abort_a); else passed++;
    wait_done(1'b0, 10);
    $display("hit: done=%b found=%b key=%0h", done_a, found_a, found_key_a);
    checks++; if ({done_a, found_a, found_key_a} !== {2'b11, 24'h00000A}) $display("FAIL hit_done: got %b%b/%0h want 11/a", done_a, found_a, found_key_a); else passed++;
    core_ready = 4'b1111; core_key = '0;
    tick();
  endtask

  task automatic test_simultaneous_hits();
    start_a = 1'b1; tick(); start_a = 1'b0;
    checks++; if ({found_a, found_key_a} !== 25'd0) $display("FAIL simul_clear_on_start: got %b/%0h want 0/0", found_a, found_key_a); else passed++;
    repeat (4) tick();
    core_ready = 4'b0000;
    core_done = 4'b1010; core_hit = 4'b1010;
    core_key[24 +: 24] = 24'h000005; core_key[72 +: 24] = 24'h00000D;
    tick();
    core_done = '0; core_hit = '0;
    $display("simul: hits on cores 1,3 key=%0h abort=%b", found_key_a, core_abort_a);
    checks++; if (found_key_a !== 24'h000005) $display("FAIL simul_lowest_key: got %0h want 5", found_key_a); else passed++;
    checks++; if (core_abort_a !== 4'b0101) $display("FAIL simul_abort: got %b want 0101", core_abort_a); else passed++;
    // A late hit while aborting must not overwrite the latched key.
    core_done = 4'b0001; core_hit = 4'b0001; core_key[0 +: 24] = 24'h000009;
    tick();
    core_done = '0; core_hit = '0;
    checks++; if ({core_abort_a, found_key_a} !== {4'b0100, 24'h000005}) $display("FAIL simul_late_hit: got %b/%0h want 0100/5", core_abort_a, found_key_a); else passed++;
    core_ready = 4'b0100;
    tick();
    checks++; if (core_abort_a !== 4'b0000) $display("FAIL simul_abort_release: got %b want 0000", core_abort_a); else passed++;
    wait_done(1'b0, 10);
    $display("simul: done=%b found=%b key=%0h", done_a, found_a, found_key_a);
    checks++; if ({done_a, found_a, found_key_a} !== {2'b11, 24'h000005}) $display("FAIL simul_done: got %b%b/%0h want 11/5", done_a, found_a, found_key_a); else passed++;
    core_ready = 4'b1111; core_key = '0;
    tick();
  endtask

  task automatic test_hit_in_dispatch();
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    checks++; if (core_start_a !== 4'b0001) $display("FAIL disp_first_grant: got %b want 0001", core_start_a); else passed++;
    core_done = 4'b0001; core_hit = 4'b0001; core_key[0 +: 24] = 24'h000002;
    tick();
    core_done = '0; core_hit = '0;
    $display("disp hit: core_start=%b found=%b key=%0h", core_start_a, found_a, found_key_a);
    checks++; if (core_start_a !== 4'b0000) $display("FAIL disp_issue_suppressed: got %b want 0000", core_start_a); else passed++;
    checks++; if ({found_a, found_key_a} !== {1'b1, 24'h000002}) $display("FAIL disp_latch: got %b/%0h want 1/2", found_a, found_key_a); else passed++;
    wait_done(1'b0, 10);
    checks++; if ({done_a, busy_a} !== 2'b10) $display("FAIL disp_done: got %b want 10", {done_a, busy_a}); else passed++;
    core_key = '0;
    tick();
  endtask

  task automatic test_reset_mid_dispatch();
    // Pointer is at core 1 after the previous test's single grant to core 0.
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    checks++; if ({core_start_a, core_base_a} !== {4'b0010, 24'd0}) $display("FAIL mid_first_grant: got %b/%0d want 0010/0", core_start_a, core_base_a); else passed++;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    $display("busy start: core_start=%b base=%0d busy=%b", core_start_a, core_base_a, busy_a);
    checks++; if ({core_start_a, core_base_a, busy_a} !== {4'b0100, 24'd4, 1'b1}) $display("FAIL busy_start_ignored: got %b/%0d/%b want 0100/4/1", core_start_a, core_base_a, busy_a); else passed++;
    reset = 1'b0;
    tick(); tick();
    $display("mid reset: busy=%b core_start=%b", busy_a, core_start_a);
    checks++; if ({busy_a, done_a, found_a, core_start_a, core_abort_a} !== 11'd0) $display("FAIL mid_reset_flags: got %b want 0", {busy_a, done_a, found_a, core_start_a, core_abort_a}); else passed++;
    checks++; if ({found_key_a, core_base_a, core_last_a} !== 72'd0) $display("FAIL mid_reset_data: got %0h/%0h/%0h want 0/0/0", found_key_a, core_base_a, core_last_a); else passed++;
    reset = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    checks++; if ({core_start_a, core_base_a, core_last_a} !== {4'b0001, 24'd0, 24'd3}) $display("FAIL mid_restart_grant: got %b/%0d/%0d want 0001/0/3", core_start_a, core_base_a, core_last_a); else passed++;
    reset = 1'b0; tick(); reset = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    core_ready = '0; core_done = '0; core_hit = '0; core_key = '0;
    test_reset();
    test_sweep();
    test_clip();
    test_hit();
    test_simultaneous_hits();
    test_hit_in_dispatch();
    test_reset_mid_dispatch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rc4_crack_scheduler.md
RC4_CRACK_SCHEDULER -- requirements
Module: rc4_crack_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of attached RC4 cracker cores.
REQ-002 SHALL have parameter CHUNK, default 24'h010000, keys per dispatched chunk.
REQ-003 SHALL have parameter KEY_MAX, default 24'h3FFFFF, last key of the search space.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising clk).
REQ-006 SHALL have port start  in  1  one-cycle request to begin a search.
REQ-007 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  out  1  one-cycle pulse when the search ends.
REQ-009 SHALL have port found  out  1  search result; valid from done until the next accepted start.
REQ-010 SHALL have port found_key  out  24  winning key; valid while found=1.
REQ-011 SHALL have port core_start  out  NUM_CORES  one-hot, one-cycle chunk-issue pulse.
REQ-012 SHALL have port core_base  out  24  first key of the issued chunk; valid with core_start.
REQ-013 SHALL have port core_last  out  24  last key of the issued chunk; valid with core_start.
REQ-014 SHALL have port core_abort  out  NUM_CORES  per-core level; stop the current chunk.
REQ-015 SHALL have port core_ready  in  NUM_CORES  core idle and able to accept a chunk.
REQ-016 SHALL have port core_done  in  NUM_CORES  one-cycle pulse; chunk finished.
REQ-017 SHALL have port core_hit  in  NUM_CORES  qualified by core_done; key found in chunk.
REQ-018 SHALL have port core_key  in  NUM_CORES*24  core i key at bits [24*i+23:24*i]; qualified by core_done[i] & core_hit[i].

Function
REQ-019 SHALL implement FSM states IDLE, DISPATCH, DRAIN, ABORT, FINISH.
REQ-020 SHALL, in IDLE with start=1, clear next_base, the assigned mask, found and found_key, then enter DISPATCH; busy=1 from the next cycle.
REQ-021 SHALL ignore start in every state except IDLE.
REQ-022 SHALL, in DISPATCH, issue at most one chunk per cycle to a core with core_ready=1 and assigned=0, chosen round-robin starting at the index after the last grant (index 0 after reset).
REQ-023 SHALL, on issue to core g, assert core_start[g] for one cycle with core_base=next_base and core_last=min(next_base+CHUNK-1, KEY_MAX), set assigned[g], and advance next_base by CHUNK.
REQ-024 SHALL compute next_base and core_last in 25 bits so no wrap-around occurs; the space is exhausted when next_base > KEY_MAX.
REQ-025 SHALL enter DRAIN on the cycle exhaustion is reached.
REQ-026 SHALL clear assigned[i] on core_done[i]; a core whose done arrives in a given cycle SHALL NOT be re-granted in that same cycle.
REQ-027 SHALL, on any core_done[i]&core_hit[i] in DISPATCH or DRAIN, latch found=1 and found_key from the lowest such index, suppress core_start that cycle, and enter ABORT.
REQ-028 SHALL, in ABORT, hold core_abort[i]=assigned[i] and clear assigned[i] when core_ready[i]=1 or core_done[i]=1; later hits are ignored; enter FINISH when assigned is zero.
REQ-029 SHALL, in DRAIN, enter FINISH with found=0 when assigned is zero and no hit occurred.
REQ-030 SHALL, in FINISH, pulse done for one cycle, deassert busy, and return to IDLE.
REQ-031 SHALL keep core_base and core_last at 0 whenever core_start is 0.

Reset
REQ-032 SHALL, on reset=0, force state IDLE; busy, done, found, core_start and core_abort to 0; found_key, core_base, core_last, next_base, the assigned mask and the round-robin pointer to 0. This applies at any time, including mid-search.
REQ-033 SHALL give reset priority over start and all core inputs.

Verification
REQ-034 SHALL verify reset: reset=0 for 2 cycles -> all outputs 0, busy=0, IDLE.
REQ-035 SHALL verify a full sweep with NUM_CORES=4, CHUNK=4, KEY_MAX=15, all cores ready, done 10 cycles after start, no hit -> core_start 0001,0010,0100,1000 on consecutive cycles; bases 0,4,8,12; lasts 3,7,11,15; then done=1 with found=0.
REQ-036 SHALL verify clipping with KEY_MAX=13 -> fourth chunk base 12, last 13; no fifth issue.
REQ-037 SHALL verify a hit: core 2 done&hit with core_key=24'h00000A -> core_abort=1011 until those cores report ready, then done=1, found=1, found_key=24'h00000A.
REQ-038 SHALL verify simultaneous hits on cores 1 (key 5) and 3 (key 13) -> found_key=24'h000005.
REQ-039 SHALL verify reset mid-DISPATCH and start while busy -> after reset=0 all outputs 0; a start while busy produces no effect and no re-initialisation.
